multi_cycle_shift_unit: RTL and testbench

// Iterative, handshaked shift engine. It shifts an N-bit operand left, right-logical or

---
 rtl/multi_cycle_shift_unit.sv | 110 +++++++++++
 tb/tb_multi_cycle_shift_unit.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/multi_cycle_shift_unit.sv
// multi_cycle_shift_unit
// Iterative shift engine: left, right-logical or right-arithmetic shift of an
// N-bit operand by a run-time amount, at most STEP positions per clock.
// Valid/ready handshake on both sides, one transaction in flight.
// The accepting edge counts as the first edge of the transaction, so a
// result for amount 0 is presented right after the accepting edge.
module multi_cycle_shift_unit #(
   parameter  int N    = 8,
   parameter  int STEP = 3,
   localparam int AW   = $clog2(N + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          up_valid,
   output logic          up_ready,
   input  logic [N-1:0]  up_data,
   input  logic [AW-1:0] up_amt,
   input  logic          up_dir,
   input  logic          up_arith,
   output logic          down_valid,
   input  logic          down_ready,
   output logic [N-1:0]  down_data,
   output logic          busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      OUT   = 2'd2
   } state_t;

   localparam logic [AW-1:0] STEP_A = AW'(STEP);
   localparam logic [AW-1:0] N_A    = AW'(N);

   state_t          state_q, state_d;
   logic [N-1:0]    work_q;      // working register being shifted
   logic [AW-1:0]   rem_q;       // positions still to shift
   logic            dir_q;       // 1 = left
   logic            fill_q;      // bit shifted in on right shifts
   logic [N-1:0]    result_q;    // last completed result

   logic [AW-1:0]   amt_sat;
   logic [AW-1:0]   step_k;
   logic [AW-1:0]   rem_next;
   logic [2*N-1:0]  right_wide;
   logic [N-1:0]    shift_res;

   // Amounts above N behave exactly like N: all operand bits are shifted out.
   assign amt_sat  = (up_amt > N_A) ? N_A : up_amt;

   // Per-cycle step never exceeds what remains, so rem cannot underflow.
   assign step_k   = (rem_q > STEP_A) ? STEP_A : rem_q;
   assign rem_next = rem_q - step_k;

   // Right shifts pull the fill bit in from a replicated upper half.
   assign right_wide = {{N{fill_q}}, work_q} >> step_k;
   assign shift_res  = dir_q ? (work_q << step_k) : right_wide[N-1:0];

   assign up_ready   = (state_q == IDLE);
   assign down_valid = (state_q == OUT);
   assign busy       = (state_q != IDLE);
   assign down_data  = result_q;

   // Next-state decode for the IDLE -> SHIFT -> OUT sequence.
   always_comb begin
      // NOTE: default assigned first so every path drives state_d; no latch is inferred.
      state_d = state_q;
      case (state_q)
         IDLE:    if (up_valid) state_d = (amt_sat == '0) ? OUT : SHIFT;
         SHIFT:   if (rem_next == '0) state_d = OUT;
         OUT:     if (down_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State, operand capture, iterative shifting and result register.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      if (rst) begin
         state_q  <= IDLE;
         work_q   <= '0;
         rem_q    <= '0;
         dir_q    <= 1'b0;
         fill_q   <= 1'b0;
         result_q <= '0;
      end else begin
         state_q <= state_d;
         case (state_q)
            IDLE: begin
               if (up_valid) begin
                  work_q <= up_data;
                  rem_q  <= amt_sat;
                  dir_q  <= up_dir;
                  fill_q <= ~up_dir & up_arith & up_data[N-1];
                  if (amt_sat == '0) result_q <= up_data;
               end
            end
            SHIFT: begin
               work_q <= shift_res;
               rem_q  <= rem_next;
               if (rem_next == '0) result_q <= shift_res;
            end
            default: begin
               // OUT holds everything until the consumer takes the result.
            end
         endcase
      end
   end

endmodule

// File: tb/tb_multi_cycle_shift_unit.sv
// Self-checking bench for multi_cycle_shift_unit (N = 8, STEP = 3).
// Directed table vectors, hand-written backpressure and reset sequences,
// and a randomized soak scored against a golden shift model.
module tb_multi_cycle_shift_unit;

   localparam int N    = 8;
   localparam int STEP = 3;
   localparam int AW   = $clog2(N + 1);
   localparam int NREQ = 3000;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          up_valid = 1'b0;
   logic          up_ready;
   logic [N-1:0]  up_data = '0;
   logic [AW-1:0] up_amt = '0;
   logic          up_dir = 1'b0;
   logic          up_arith = 1'b0;
   logic          down_valid;
   logic          down_ready = 1'b0;
   logic [N-1:0]  down_data;
   logic          busy;

   int checks   = 0;
   int failures = 0;

   multi_cycle_shift_unit #(.N(N), .STEP(STEP)) dut (
      .clk        (clk),
      .rst        (rst),
      .up_valid   (up_valid),
      .up_ready   (up_ready),
      .up_data    (up_data),
      .up_amt     (up_amt),
      .up_dir     (up_dir),
      .up_arith   (up_arith),
      .down_valid (down_valid),
      .down_ready (down_ready),
      .down_data  (down_data),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [N-1:0]  d;
      logic [AW-1:0] a;
      logic          dir;
      logic          ar;
      logic [N-1:0]  exp;
      int            lat;
   } vec_t;

   vec_t vecs[9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Golden model: plain language shift operators on the saturated amount.
   function automatic logic [N-1:0] ref_shift(input logic [N-1:0] d, input logic [AW-1:0] a,
                                              input logic dir, input logic ar);
      logic signed [N-1:0] sd;
      int amt;
      amt = (int'(a) > N) ? N : int'(a);
      sd  = d;
      if (dir)     return d << amt;
      else if (ar) return sd >>> amt;
      else         return d >> amt;
   endfunction

   // Edges from (and including) the accepting edge until down_valid shows.
   function automatic int ref_latency(input logic [AW-1:0] a);
      int amt;
      amt = (int'(a) > N) ? N : int'(a);
      return (amt + STEP - 1) / STEP + 1;
   endfunction

   // Issue one request from IDLE (called at a falling edge), wait for the
   // result, take it, and confirm the unit returns to IDLE.
   task automatic do_txn(input string name, input logic [N-1:0] d, input logic [AW-1:0] a,
                         input logic dir, input logic ar,
                         output logic [N-1:0] res, output int lat);
      up_valid = 1'b1; up_data = d; up_amt = a; up_dir = dir; up_arith = ar;
      down_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      up_valid = 1'b0; up_data = N'($urandom); up_amt = AW'($urandom);
      up_dir = 1'($urandom); up_arith = 1'($urandom);
      lat = 1;
      while (!down_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      if (!down_valid) check({name, "_timeout"}, 32'(down_valid), 32'd1);
      res = down_data;
      down_ready = 1'b1;
      @(negedge clk);
      down_ready = 1'b0;
      check({name, "_valid_drop"}, 32'(down_valid), 32'd0);
      check({name, "_ready_back"}, 32'(up_ready), 32'd1);
   endtask

   logic [N-1:0] exp_q[$];

   initial begin
      logic [N-1:0] res;
      logic [N-1:0] held;
      int lat;
      int acc, got, cyc;

      vecs[0] = '{8'hB6, 4'd3,  1'b0, 1'b0, 8'h16, 2};
      vecs[1] = '{8'hB6, 4'd5,  1'b0, 1'b1, 8'hFD, 3};
      vecs[2] = '{8'hB6, 4'd5,  1'b0, 1'b0, 8'h05, 3};
      vecs[3] = '{8'hB6, 4'd0,  1'b1, 1'b0, 8'hB6, 1};
      vecs[4] = '{8'hB6, 4'd7,  1'b1, 1'b0, 8'h00, 4};
      vecs[5] = '{8'hFF, 4'd9,  1'b1, 1'b0, 8'h00, 4};
      vecs[6] = '{8'h80, 4'd12, 1'b0, 1'b1, 8'hFF, 4};
      vecs[7] = '{8'hB6, 4'd1,  1'b1, 1'b1, 8'h6C, 2};
      vecs[8] = '{8'h7F, 4'd15, 1'b0, 1'b1, 8'h00, 4};

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("reset_down_valid", 32'(down_valid), 32'd0);
      check("reset_busy",       32'(busy),       32'd0);
      check("reset_up_ready",   32'(up_ready),   32'd1);
      check("reset_down_data",  32'(down_data),  32'd0);

      // Directed table
      for (int i = 0; i < 9; i++) begin
         do_txn($sformatf("vec%0d", i), vecs[i].d, vecs[i].a, vecs[i].dir, vecs[i].ar, res, lat);
         check($sformatf("vec%0d_data", i), 32'(res), 32'(vecs[i].exp));
         check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      end

      // Backpressure: result held for 5 cycles, intervening requests ignored.
      up_valid = 1'b1; up_data = 8'hB6; up_amt = 4'd3; up_dir = 1'b0; up_arith = 1'b0;
      @(posedge clk);
      @(negedge clk);
      up_valid = 1'b0;
      lat = 1;
      while (!down_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      check("bp_valid", 32'(down_valid), 32'd1);
      held = down_data;
      check("bp_data", 32'(held), 32'h16);
      for (int c = 0; c < 5; c++) begin
         up_valid = 1'(c % 2 == 0); up_data = 8'h01; up_amt = 4'd0; up_dir = 1'b1;
         @(negedge clk);
         check($sformatf("bp_hold_data%0d", c), 32'(down_data), 32'(held));
         check($sformatf("bp_hold_valid%0d", c), 32'(down_valid), 32'd1);
         check($sformatf("bp_hold_ready%0d", c), 32'(up_ready), 32'd0);
      end
      up_valid = 1'b0;
      down_ready = 1'b1;
      @(negedge clk);
      down_ready = 1'b0;
      check("bp_release_valid", 32'(down_valid), 32'd0);
      check("bp_release_ready", 32'(up_ready),   32'd1);
      check("bp_release_busy",  32'(busy),       32'd0);
      check("bp_last_result",   32'(down_data),  32'h16);

      // Reset mid-SHIFT drops the transaction.
      up_valid = 1'b1; up_data = 8'hB6; up_amt = 4'd8; up_dir = 1'b0; up_arith = 1'b1;
      @(posedge clk);
      @(negedge clk);
      up_valid = 1'b0;
      @(negedge clk);
      check("rst_mid_busy_before", 32'(busy), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rst_mid_down_valid", 32'(down_valid), 32'd0);
      check("rst_mid_busy",       32'(busy),       32'd0);
      check("rst_mid_up_ready",   32'(up_ready),   32'd1);
      repeat (4) begin
         @(negedge clk);
         check("rst_mid_no_result", 32'(down_valid), 32'd0);
      end
      do_txn("post_rst", 8'h40, 4'd2, 1'b0, 1'b0, res, lat);
      check("post_rst_data",    32'(res), 32'h10);
      check("post_rst_latency", 32'(lat), 32'd2);

      // Random soak against the golden model.
      acc = 0; got = 0; cyc = 0;
      while (got < NREQ && cyc < 60000) begin
         @(negedge clk);
         cyc++;
         up_valid   = (acc < NREQ) && ($urandom_range(0, 1) == 1);
         up_data    = N'($urandom);
         up_amt     = AW'($urandom);
         up_dir     = 1'($urandom);
         up_arith   = 1'($urandom);
         down_ready = ($urandom_range(0, 3) != 0);
         if (up_valid && up_ready) begin
            exp_q.push_back(ref_shift(up_data, up_amt, up_dir, up_arith));
            acc++;
         end
         if (down_valid && down_ready) begin
            if (exp_q.size() == 0) check("soak_spurious", 32'd1, 32'd0);
            else check("soak_data", 32'(down_data), 32'(exp_q.pop_front()));
            got++;
         end
      end
      up_valid = 1'b0;
      down_ready = 1'b0;
      check("soak_completed", 32'(got), 32'(NREQ));
      check("soak_queue_empty", 32'(exp_q.size()), 32'd0);
      check("soak_latency_model", 32'(ref_latency(4'd8)), 32'd4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
